// File: rtl/lfsr16_pkg.sv
// lfsr16_pkg: shared timer-LFSR constants and decoder state encoding
package lfsr16_pkg;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam int unsigned SH_A = 7;
  localparam int unsigned SH_B = 9;
  localparam int unsigned SH_C = 8;
  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} dec_state_t;
endpackage

// File: rtl/lfsr16_inv_step.sv
// lfsr16_inv_step: one backward step of the x^=x<<7; x^=x>>9; x^=x<<8 timer LFSR
module lfsr16_inv_step
  import lfsr16_pkg::*;
(
  input  logic [15:0] x,
  output logic [15:0] y
);
  logic [15:0] a, b;
  assign a = x ^ (x << SH_C);
  assign b = a ^ (a >> SH_B);
  // undoing x^=x<<7 needs the second term because x<<7 feeds back once more within 16 bits
  assign y = b ^ (b << SH_A) ^ (b << (2 * SH_A));
endmodule

// File: rtl/lfsr16_decoder.sv
// lfsr16_decoder: walks Code backwards to SEED, reporting the step count
// Optional search bound enabled by defining LFSR_DEC_TIMEOUT_EN.
module lfsr16_decoder
  import lfsr16_pkg::*;
#(
  parameter logic [15:0] SEED      = LFSR_SEED,
  parameter logic [15:0] MAX_STEPS = 16'hFFFE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        Cancel,
  input  logic [15:0] Code,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Count,
  output logic        Error
);
  dec_state_t state, state_nx;
  logic [15:0] work, work_nx, step, step_nx, count_nx, inv;
  logic done_nx, error_nx, timeout;
  lfsr16_inv_step u_inv (.x(work), .y(inv));
`ifdef LFSR_DEC_TIMEOUT_EN
  assign timeout = step == MAX_STEPS;
`else
  logic unused_max;
  assign unused_max = ^MAX_STEPS;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge CLK)
    if (!RST) begin
      state <= IDLE;
      work  <= '0;
      step  <= '0;
      Count <= '0;
      Error <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nx;
      work  <= work_nx;
      step  <= step_nx;
      Count <= count_nx;
      Error <= error_nx;
      Done  <= done_nx;
    end
  always_comb begin
    state_nx = state;
    work_nx  = work;
    step_nx  = step;
    count_nx = Count;
    error_nx = Error;
    done_nx  = 1'b0;
    if (state == IDLE) begin
      if (Start) begin
        state_nx = SEARCH;
        work_nx  = Code;
        step_nx  = '0;
        error_nx = 1'b0;
      end
    end else if (Cancel) begin
      state_nx = IDLE;
    end else if (work == SEED) begin
      state_nx = IDLE;
      count_nx = step;
      done_nx  = 1'b1;
    end else if (work == '0 || timeout) begin
      state_nx = IDLE;
      count_nx = '0;
      error_nx = 1'b1;
      done_nx  = 1'b1;
    end else begin
      work_nx = inv;
      step_nx = step + 16'd1;
    end
  end
  assign Busy = state == SEARCH;
endmodule

// File: tb/tb_lfsr16_decoder.sv
// tb_lfsr16_decoder: randomized decode checks against a forward-LFSR position table
module tb_lfsr16_decoder;
`ifdef LFSR_DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam logic [15:0] TB_MAX = 16'd16;
`else
  localparam bit TO_EN = 1'b0;
  localparam logic [15:0] TB_MAX = 16'hFFFE;
`endif
  logic CLK = 1'b0, RST = 1'b0, Start = 1'b0, Cancel = 1'b0;
  logic [15:0] Code = '0;
  logic Busy, Done, Error;
  logic [15:0] Count;
  int checks = 0, errors = 0;
  int pos [0:65535];

  lfsr16_decoder #(.SEED(16'hFFFF), .MAX_STEPS(TB_MAX)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Cancel(Cancel), .Code(Code),
    .Busy(Busy), .Done(Done), .Count(Count), .Error(Error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [15:0] v);
    logic [15:0] x;
    x = v;
    x ^= x << 7;
    x ^= x >> 9;
    x ^= x << 8;
    return x;
  endfunction

  function automatic logic [15:0] fwd_n(input int n);
    logic [15:0] x;
    x = 16'hFFFF;
    for (int i = 0; i < n; i++) x = fwd(x);
    return x;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // poke_at >= 0 injects Cancel (or a competing Start) after that many search cycles
  task automatic decode(input logic [15:0] code, input int poke_at, input bit poke_cancel, input string tag);
    int lat, k, exp_lat, exp_cnt, exp_err, prev_cnt;
    k = (code == 16'h0) ? -1 : pos[code];
    if (k < 0) begin exp_err = 1; exp_cnt = 0; exp_lat = 1; end
    else if (TO_EN && k > int'(TB_MAX)) begin exp_err = 1; exp_cnt = 0; exp_lat = int'(TB_MAX) + 1; end
    else begin exp_err = 0; exp_cnt = k; exp_lat = k + 1; end
    prev_cnt = int'(Count);
    Code = code;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    lat = 0;
    check({tag, "/busy_on"}, int'(Busy), 1);
    while (!Done && Busy && lat < 70000) begin
      if (lat == poke_at) begin
        if (poke_cancel) Cancel = 1'b1;
        else begin Start = 1'b1; Code = 16'h1234; end
      end
      tick();
      Cancel = 1'b0;
      Start = 1'b0;
      Code = code;
      lat++;
    end
    if (poke_cancel) begin
      check({tag, "/cancel_lat"}, lat, poke_at + 1);
      check({tag, "/cancel_done"}, int'(Done), 0);
      check({tag, "/cancel_busy"}, int'(Busy), 0);
      check({tag, "/cancel_cnt"}, int'(Count), prev_cnt);
      check({tag, "/cancel_err"}, int'(Error), 0);
    end else begin
      check({tag, "/done"}, int'(Done), 1);
      check({tag, "/lat"}, lat, exp_lat);
      check({tag, "/cnt"}, int'(Count), exp_cnt);
      check({tag, "/err"}, int'(Error), exp_err);
      check({tag, "/busy_off"}, int'(Busy), 0);
      tick();
      check({tag, "/done_pulse"}, int'(Done), 0);
      check({tag, "/cnt_hold"}, int'(Count), exp_cnt);
    end
  endtask

  initial begin
    logic [15:0] x;
    int r;
    for (int i = 0; i < 65536; i++) pos[i] = -1;
    x = 16'hFFFF;
    for (int i = 0; i < 65535; i++) begin
      pos[x] = i;
      x = fwd(x);
    end
    repeat (3) tick();
    check("rst/busy", int'(Busy), 0);
    check("rst/done", int'(Done), 0);
    check("rst/cnt", int'(Count), 0);
    check("rst/err", int'(Error), 0);
    RST = 1'b1;
    tick();
    decode(16'hFFFF, -1, 0, "seed");
    decode(16'h7F7F, -1, 0, "step1");
    decode(16'h5F9F, -1, 0, "step2");
    decode(16'h0000, -1, 0, "zero");
    decode(fwd_n(20), -1, 0, "step20");
    decode(fwd_n(16), -1, 0, "step16");
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 400);
      decode(fwd_n(r), -1, 0, $sformatf("rnd%0d_k%0d", i, r));
    end
    decode(fwd_n(10), 3, 0, "restart_ignored");
    decode(fwd_n(12), 5, 1, "cancel_mid");
    decode(fwd_n(8), 8, 1, "cancel_at_match");
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    check("idle_cancel/busy", int'(Busy), 0);
    check("idle_cancel/done", int'(Done), 0);
    decode(fwd_n(1000), -1, 0, "trip1000");
    Code = fwd_n(1000);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (500) tick();
    RST = 1'b0;
    tick();
    check("midrst/busy", int'(Busy), 0);
    check("midrst/done", int'(Done), 0);
    check("midrst/cnt", int'(Count), 0);
    check("midrst/err", int'(Error), 0);
    RST = 1'b1;
    tick();
    decode(fwd_n(65534), -1, 0, "trip65534");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
